// File: rtl/popcount_feeder.sv
// popcount_feeder: buffers producer words in a small FIFO and hands them to
// the population counter one at a time, waiting for each word's completion
// (rising edge of pc_done_i) or a timeout before issuing the next.
//
// Handshake: the producer side is valid/ready. A word moves when data_val_i
// and data_ready_o are both high at a rising clk_i edge; while ready is low
// the producer holds its word and data_val_i is ignored. The counter side has
// no ready: pc_data_val_o is a one-cycle pulse, and pc_done_i is the
// counter's level-type completion flag.
module popcount_feeder #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       data_val_i,
  output logic                       data_ready_o,
  output logic [WIDTH-1:0]           pc_data_o,
  output logic                       pc_data_val_o,
  input  logic                       pc_done_i,
  output logic [$clog2(DEPTH):0]     used_o,
  output logic                       timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [TW-1:0]     timer_q;
  logic              done_q;

  logic              wr_en;
  logic              rd_en;
  logic              done_rise;
  logic              timer_exp;
  logic [UW-1:0]     used_nxt;

  // Handshake decode, issue decision and next occupancy.
  always_comb begin
    wr_en     = data_val_i & data_ready_o;
    rd_en     = (state_q == ST_IDLE) && (used_o != '0);
    done_rise = pc_done_i & ~done_q;
    timer_exp = (timer_q == TW'(TIMEOUT - 1));
    used_nxt  = used_o + UW'(wr_en) - UW'(rd_en);
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      used_o       <= '0;
      data_ready_o <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      used_o       <= used_nxt;
      data_ready_o <= (used_nxt < UW'(DEPTH));
    end
  end

  // Completion edge detector; a stale high done level never looks like a rise.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= pc_done_i;
    end
  end

  // Issue FSM: pop and pulse in IDLE, then wait for done_rise or timeout.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q       <= ST_IDLE;
      pc_data_o     <= '0;
      pc_data_val_o <= 1'b0;
      timeout_o     <= 1'b0;
      timer_q       <= '0;
    end else begin
      pc_data_val_o <= 1'b0;
      timeout_o     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rd_en) begin
            pc_data_o     <= mem[rd_ptr_q];
            pc_data_val_o <= 1'b1;
            timer_q       <= '0;
            state_q       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (done_rise) begin
            // Completion beats a coincident timeout.
            state_q <= ST_IDLE;
          end else if (timer_exp) begin
            // Outstanding word is abandoned.
            timeout_o <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_feeder.sv
// tb_popcount_feeder: directed bench for popcount_feeder with a simple counter
// model that raises done a programmable number of cycles after capture.
module tb_popcount_feeder;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic              clk_i;
  logic              arstn_i;
  logic [WIDTH-1:0]  data_i;
  logic              data_val_i;
  logic              data_ready_o;
  logic [WIDTH-1:0]  pc_data_o;
  logic              pc_data_val_o;
  logic              pc_done_i;
  logic [$clog2(DEPTH):0] used_o;
  logic              timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] exp_q[$];
  int  issue_cnt = 0;
  int  tout_cnt  = 0;
  bit  saw_full  = 0;

  // counter model controls/state
  bit  model_en    = 1;
  int  model_delay = 10;
  bit  busy;
  int  cnt;

  popcount_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .data_i        (data_i),
    .data_val_i    (data_val_i),
    .data_ready_o  (data_ready_o),
    .pc_data_o     (pc_data_o),
    .pc_data_val_o (pc_data_val_o),
    .pc_done_i     (pc_done_i),
    .used_o        (used_o),
    .timeout_o     (timeout_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // ---------------- counter model ----------------
  always @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pc_done_i <= 1'b0;
      busy      <= 1'b0;
      cnt       <= 0;
    end else if (pc_data_val_o) begin
      pc_done_i <= 1'b0;
      busy      <= 1'b1;
      cnt       <= model_delay;
    end else if (busy) begin
      if (cnt == 1) begin
        busy <= 1'b0;
        if (model_en) pc_done_i <= 1'b1;
      end
      cnt <= cnt - 1;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk_i) begin
    if (arstn_i) begin
      if (pc_data_val_o) begin
        issue_cnt++;
        check("no_overlap", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0)
          check("issue_unexpected", 32'd1, 32'd0);
        else
          check("issue_data", {24'd0, pc_data_o}, {24'd0, exp_q.pop_front()});
      end
      if (timeout_o) tout_cnt++;
      if (used_o == DEPTH) begin
        saw_full = 1;
        check("ready_full", {31'd0, data_ready_o}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] w);
    int n;
    data_i     = w;
    data_val_i = 1'b1;
    n = 0;
    while (!data_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) check("send_timeout", 32'd1, 32'd0);
    else exp_q.push_back(w);
    @(negedge clk_i);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || used_o != 0) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'd1, 32'd0);
    repeat (15) @(negedge clk_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int t0;
    int ic;
    arstn_i    = 1'b0;
    data_i     = '0;
    data_val_i = 1'b0;

    // reset state
    #12;
    check("rst_used",  32'(used_o), 32'd0);
    check("rst_val",   {31'd0, pc_data_val_o}, 32'd0);
    check("rst_ready", {31'd0, data_ready_o}, 32'd0);
    check("rst_tout",  {31'd0, timeout_o}, 32'd0);
    check("rst_data",  {24'd0, pc_data_o}, 32'd0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    check("ready_before_edge", {31'd0, data_ready_o}, 32'd0);
    @(negedge clk_i);
    check("ready_after_edge", {31'd0, data_ready_o}, 32'd1);

    // 1: single word
    send(8'hA5);
    data_val_i = 1'b0;
    check("t1_used_after_write", 32'(used_o), 32'd1);
    check("t1_val_before_issue", {31'd0, pc_data_val_o}, 32'd0);
    @(negedge clk_i);
    check("t1_val_issue", {31'd0, pc_data_val_o}, 32'd1);
    check("t1_data",      {24'd0, pc_data_o}, 32'h000000A5);
    check("t1_used_after_issue", 32'(used_o), 32'd0);
    @(negedge clk_i);
    check("t1_val_one_cycle", {31'd0, pc_data_val_o}, 32'd0);
    check("t1_data_held",     {24'd0, pc_data_o}, 32'h000000A5);
    ic = issue_cnt;
    repeat (20) @(negedge clk_i);
    check("t1_no_extra_pulse", 32'(issue_cnt), 32'(ic));

    // 2: burst of 6 with valid held high
    ic = issue_cnt;
    for (int i = 1; i <= 6; i++) send(WIDTH'(i));
    data_val_i = 1'b0;
    drain();
    check("t2_saw_full", {31'd0, saw_full}, 32'd1);
    check("t2_issue_count", 32'(issue_cnt - ic), 32'd6);
    check("t2_used_empty", 32'(used_o), 32'd0);

    // 3: simultaneous write and issue with two words buffered
    send(8'h10);
    send(8'h20);
    send(8'h30);
    data_val_i = 1'b0;
    check("t3_used_two", 32'(used_o), 32'd2);
    k = 0;
    while (!pc_done_i && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    check("t3_done_seen", {31'd0, pc_done_i}, 32'd1);
    @(negedge clk_i);
    send(8'h40);
    data_val_i = 1'b0;
    check("t3_used_kept", 32'(used_o), 32'd2);
    check("t3_issue_same_edge", {31'd0, pc_data_val_o}, 32'd1);
    drain();

    // 4: timeout when done never comes
    model_en = 0;
    t0 = tout_cnt;
    send(8'h3C);
    send(8'hC3);
    data_val_i = 1'b0;
    check("t4_issue_seen", {31'd0, pc_data_val_o}, 32'd1);
    k = 0;
    while (!timeout_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    check("t4_timeout_latency", 32'(k), 32'd64);
    model_en = 1;
    @(negedge clk_i);
    check("t4_timeout_one_cycle", {31'd0, timeout_o}, 32'd0);
    check("t4_next_issue", {31'd0, pc_data_val_o}, 32'd1);
    drain();
    check("t4_timeout_count", 32'(tout_cnt - t0), 32'd1);

    // 5: done_rise coincides with the last timer cycle
    model_delay = 62;
    t0 = tout_cnt;
    send(8'h5A);
    send(8'h77);
    data_val_i = 1'b0;
    check("t5_issue_seen", {31'd0, pc_data_val_o}, 32'd1);
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!pc_data_val_o && k < 100);
    model_delay = 10;
    check("t5_next_issue_latency", 32'(k), 32'd65);
    drain();
    check("t5_no_timeout", 32'(tout_cnt - t0), 32'd0);

    // 6: asynchronous reset mid-WAIT with words buffered
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    data_val_i = 1'b0;
    check("t6_used_three", 32'(used_o), 32'd3);
    repeat (3) @(negedge clk_i);
    #3;
    arstn_i = 1'b0;
    #1;
    check("t6_rst_used",  32'(used_o), 32'd0);
    check("t6_rst_val",   {31'd0, pc_data_val_o}, 32'd0);
    check("t6_rst_ready", {31'd0, data_ready_o}, 32'd0);
    exp_q.delete();
    ic = issue_cnt;
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);
    check("t6_ready_after_release", {31'd0, data_ready_o}, 32'd1);
    repeat (40) @(negedge clk_i);
    check("t6_no_stale_issue", 32'(issue_cnt), 32'(ic));
    check("t6_used_empty", 32'(used_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/popcount_feeder.md
Name: popcount_feeder

Overview:
- Upstream stage of the bit population counter.
- The counter has no ready signal. It ignores data_val_i while busy, and its data_val_o stays high from the end of a count until the next word is accepted.
- This block buffers incoming words in a small FIFO and issues exactly one word at a time to the counter. It waits for that word's completion before issuing the next, so no word is lost.
- Sits between a valid/ready producer and the counter's data_i/data_val_i; the counter's data_val_o is fed back as pc_done_i.

Parameters:
WIDTH, 8, word width; must match the counter's WIDTH
DEPTH, 4, FIFO depth in words; power of two, >= 2
TIMEOUT, 64, max cycles in WAIT before abandoning the outstanding word; >= 2*WIDTH+4

Ports:
clk_i  input  1  clock, all logic on rising edge
arstn_i  input  1  reset; asynchronous, active-low
data_i  input  WIDTH  producer word
data_val_i  input  1  producer valid
data_ready_o  output  1  FIFO can accept; a word is transferred when data_val_i & data_ready_o at an edge
pc_data_o  output  WIDTH  word to counter data_i
pc_data_val_o  output  1  one-cycle issue pulse to counter data_val_i
pc_done_i  input  1  counter data_val_o (level)
used_o  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
timeout_o  output  1  one-cycle pulse when TIMEOUT expires

Behaviour:
- Reset (arstn_i low, asynchronous):
  - FIFO emptied; pointers and used_o = 0.
  - pc_data_o = 0, pc_data_val_o = 0, timeout_o = 0, data_ready_o = 0.
  - FSM = IDLE, timer = 0, done_q = 0.
  - A reset in any state discards buffered and outstanding words.
- All outputs are registered.
- data_ready_o:
  - Reset value 0.
  - Becomes 1 at the first edge after arstn_i rises.
  - Thereafter equals (post-edge occupancy < DEPTH).
- FIFO:
  - Write on data_val_i & data_ready_o.
  - Read on the issue edge.
  - Simultaneous write and read leaves used_o unchanged.
  - A write while full cannot occur, since ready is low. data_val_i while ready is low is ignored; the producer holds its word.
  - Pointers wrap modulo DEPTH.
- Done detection: done_q registers pc_done_i; done_rise = pc_done_i & ~done_q.
- FSM states:
  - IDLE: at an edge with used_o > 0 → pop head into pc_data_o, set pc_data_val_o = 1, clear timer, go to WAIT. Otherwise stay; pc_data_val_o = 0.
  - WAIT:
    - pc_data_val_o returns to 0 after one cycle.
    - pc_data_o holds the issued word until the next issue.
    - Timer increments each cycle.
    - On done_rise → IDLE.
    - On timer reaching TIMEOUT-1 with no done_rise → timeout_o = 1 for one cycle, go to IDLE, word considered lost.
    - done_rise and timeout on the same edge → done wins, no timeout pulse.
  - done_rise in IDLE is ignored.
- Issue timing:
  - Word accepted into an empty FIFO at edge E with FSM in IDLE.
  - used_o = 1 after E.
  - Pulse high during cycle E+1..E+2 (FSM issues at edge E+1).
  - Counter captures the word at edge E+2.
- Rate: back-to-back issues are separated by at least 2 cycles after done_rise, because done must rise then IDLE issues. The pulse therefore never overlaps a busy counter.
- The stale high level of pc_done_i left from the previous word does not produce a rise, since done_q is already 1.
- used_o is updated on the same edge as the FIFO operation.

Test Plan:
(Bench uses WIDTH=8, DEPTH=4, TIMEOUT=64 and a counter model asserting done 10 cycles after capture. Where the model drops done, it holds done until the next capture.)
1. Reset then single word 8'hA5 at edge 0 → used_o = 1 after edge 0; pc_data_val_o high for exactly cycle 1; pc_data_o = 8'hA5; no further pulse until done_rise; used_o = 0.
2. Burst of 6 words 1..6, data_val_i held high → data_ready_o drops once used_o = 4; all 6 issued in order 1..6; exactly one pulse per done_rise; no duplicates, no losses.
3. Simultaneous write and issue with used_o = 2 → used_o stays 2 across that edge; order preserved.
4. Model never asserts done → timeout_o pulses once, 64 cycles after the issue edge; FSM returns to IDLE; the next word is issued on the following edge.
5. done_rise on the same edge as timer reaching 63 → no timeout_o; normal return to IDLE.
6. arstn_i asserted asynchronously mid-WAIT with 3 words buffered → used_o = 0, pc_data_val_o = 0, data_ready_o = 0 immediately. After release: ready = 1 after one edge, and no stale word is issued.
